// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Sequencing controller for the fetch stage. Generates the PC
//            enable (enbl), the redirect/NOP select (dec) and the redirect
//            address (pc_mux). It covers the post-reset boot wait for the
//            synchronous instruction memory, hazard stalls, branch
//            redirect/flush and halt/resume.
//            All outputs are registered on posedge clk, so they are stable
//            before the fetch stage updates its PC on the negedge.
// Ports    : clk, rst (async, active-high)
//            stall_req     - hazard stall request (level)
//            branch_taken  - one-cycle redirect pulse
//            branch_target - redirect address, valid with branch_taken
//            halt_req      - stop fetching (level)
//            resume        - leave HALT (pulse)
//            enbl          - fetch PC enable
//            dec           - redirect select (PC <= pc_mux, DR <= NOP)
//            pc_mux        - redirect address
//            state_o       - current FSM state, for debug
//            stall_cnt, flush_cnt - performance counters (optional build)
// Options  : FETCH_CTRL_PERF_EN - when defined, adds the saturating 16-bit
//            stall_cnt / flush_cnt outputs. FSM behaviour is unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int PC_W         = 7,
    parameter int BOOT_CYCLES  = 2,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_req,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            halt_req,
    input  logic            resume,
    output logic            enbl,
    output logic            dec,
    output logic [PC_W-1:0] pc_mux,
    output logic [2:0]      state_o
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [15:0]     stall_cnt,
    output logic [15:0]     flush_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STALL = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [3:0] c_BOOT_LAST  = 4'(BOOT_CYCLES);
    localparam logic [2:0] c_FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t     r_state;
    logic [3:0] r_boot_cnt;
    logic [2:0] r_flush_cnt;

    state_t     w_next;
    logic       w_branch;   // branch accepted this cycle

    // Next-state decision. Branch beats halt beats stall in RUN/STALL/FLUSH;
    // inside FLUSH, halt/stall are only looked at once the flush expires.
    always_comb begin
        w_next   = r_state;
        w_branch = 1'b0;
        case (r_state)
            ST_BOOT: begin
                // Counter reaches BOOT_CYCLES after that many posedges in BOOT,
                // so the move to RUN happens on the following posedge.
                if (r_boot_cnt == c_BOOT_LAST)
                    w_next = ST_RUN;
            end
            ST_RUN, ST_STALL: begin
                if (branch_taken) begin
                    w_next   = ST_FLUSH;
                    w_branch = 1'b1;
                end else if (halt_req) begin
                    w_next = ST_HALT;
                end else if (stall_req) begin
                    w_next = ST_STALL;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (branch_taken) begin
                    w_next   = ST_FLUSH;
                    w_branch = 1'b1;
                end else if (r_flush_cnt <= 3'd1) begin
                    if (halt_req)
                        w_next = ST_HALT;
                    else if (stall_req)
                        w_next = ST_STALL;
                    else
                        w_next = ST_RUN;
                end
            end
            ST_HALT: begin
                if (resume && !halt_req)
                    w_next = ST_RUN;
            end
            default: w_next = ST_BOOT;  // illegal encodings recover to BOOT
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_BOOT;
            r_boot_cnt  <= 4'd0;
            r_flush_cnt <= 3'd0;
            enbl        <= 1'b0;
            dec         <= 1'b0;
            pc_mux      <= '0;
        end else begin
            r_state <= w_next;

            // Counter is only meaningful while BOOT persists; clearing it on
            // every other path also makes illegal-state recovery start fresh.
            if (r_state == ST_BOOT && w_next == ST_BOOT)
                r_boot_cnt <= r_boot_cnt + 4'd1;
            else
                r_boot_cnt <= 4'd0;

            if (w_branch)
                r_flush_cnt <= c_FLUSH_LOAD;
            else if (r_state == ST_FLUSH && r_flush_cnt != 3'd0)
                r_flush_cnt <= r_flush_cnt - 3'd1;

            if (w_branch)
                pc_mux <= branch_target;

            // Outputs decoded from the next state so they line up with it.
            enbl <= (w_next == ST_RUN) || (w_next == ST_FLUSH);
            dec  <= (w_next == ST_FLUSH);
        end
    end

    assign state_o = r_state;

`ifdef FETCH_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (r_state == ST_STALL && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (w_branch && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Self-checking bench for fetch_ctrl. Two instances (default
//            parameters and BOOT_CYCLES=4/FLUSH_CYCLES=3) share one stimulus
//            stream; a behavioural model of each is stepped every posedge and
//            compared against the registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall_req = 1'b0;
    logic       branch_taken = 1'b0;
    logic [6:0] branch_target = 7'd0;
    logic       halt_req = 1'b0;
    logic       resume = 1'b0;

    logic       a_enbl, a_dec, b_enbl, b_dec;
    logic [6:0] a_pc, b_pc;
    logic [2:0] a_state, b_state;

    always #5 clk = ~clk;

    fetch_ctrl #(.PC_W(7), .BOOT_CYCLES(2), .FLUSH_CYCLES(1)) u_dut_a (
        .clk(clk), .rst(rst), .stall_req(stall_req), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt_req(halt_req), .resume(resume),
        .enbl(a_enbl), .dec(a_dec), .pc_mux(a_pc), .state_o(a_state)
    );

    fetch_ctrl #(.PC_W(7), .BOOT_CYCLES(4), .FLUSH_CYCLES(3)) u_dut_b (
        .clk(clk), .rst(rst), .stall_req(stall_req), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt_req(halt_req), .resume(resume),
        .enbl(b_enbl), .dec(b_dec), .pc_mux(b_pc), .state_o(b_state)
    );

    // Behavioural model: mode numbers are the debug encoding seen on state_o.
    localparam int c_BOOT = 0, c_RUN = 1, c_STALL = 2, c_FLUSH = 3, c_HALT = 4;
    int         m_boot_n[2]  = '{2, 4};
    int         m_flush_n[2] = '{1, 3};
    int         m_mode[2];
    int         m_since_rst[2];   // posedges seen since reset release
    int         m_flush_left[2];  // flush cycles still to run
    logic [6:0] m_pc[2];

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k]       = c_BOOT;
            m_since_rst[k]  = 0;
            m_flush_left[k] = 0;
            m_pc[k]         = 7'd0;
        end
    endtask

    task automatic model_step(input int k, input logic s, input logic b, input logic [6:0] t,
                              input logic h, input logic r);
        if (m_mode[k] == c_BOOT) begin
            m_since_rst[k]++;
            if (m_since_rst[k] > m_boot_n[k])
                m_mode[k] = c_RUN;
        end else if (m_mode[k] == c_HALT) begin
            if (r && !h)
                m_mode[k] = c_RUN;
        end else if (b) begin
            m_pc[k]         = t;
            m_mode[k]       = c_FLUSH;
            m_flush_left[k] = m_flush_n[k];
        end else if (m_mode[k] == c_FLUSH) begin
            m_flush_left[k]--;
            if (m_flush_left[k] == 0)
                m_mode[k] = h ? c_HALT : (s ? c_STALL : c_RUN);
        end else begin
            m_mode[k] = h ? c_HALT : (s ? c_STALL : c_RUN);
        end
    endtask

    function automatic logic [31:0] exp_word(input int k);
        logic e;
        logic d;
        e = (m_mode[k] == c_RUN) || (m_mode[k] == c_FLUSH);
        d = (m_mode[k] == c_FLUSH);
        return {20'd0, 3'(m_mode[k]), e, d, m_pc[k]};
    endfunction

    task automatic check_models(input string tag);
        check_val({tag, "/a"}, {20'd0, a_state, a_enbl, a_dec, a_pc}, exp_word(0));
        check_val({tag, "/b"}, {20'd0, b_state, b_enbl, b_dec, b_pc}, exp_word(1));
    endtask

    // One clock: drive at negedge, step model at posedge, compare just after.
    task automatic cycle(input logic s, input logic b, input logic [6:0] t,
                         input logic h, input logic r, input string tag);
        @(negedge clk);
        stall_req = s; branch_taken = b; branch_target = t; halt_req = h; resume = r;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, s, b, t, h, r);
        #1 check_models(tag);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        stall_req = 0; branch_taken = 0; halt_req = 0; resume = 0;
        model_reset();
        #1 check_models(tag);
        check_val({tag, "/b_dec_enbl"}, {30'd0, b_dec, b_enbl}, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    logic rs, rh, rb, rr;
    logic [6:0] rt;

    initial begin
        model_reset();
        do_reset("reset");

        // Boot wait: enbl low for two posedges after release, then RUN.
        cycle(0, 0, 7'd0, 0, 0, "boot1"); check_val("boot1_enbl", {31'd0, a_enbl}, 32'd0);
        cycle(0, 0, 7'd0, 0, 0, "boot2"); check_val("boot2_enbl", {31'd0, a_enbl}, 32'd0);
        cycle(0, 0, 7'd0, 0, 0, "boot3");
        check_val("boot_run", {27'd0, a_state, a_enbl, a_dec}, {27'd0, 3'd1, 1'b1, 1'b0});
        repeat (2) cycle(0, 0, 7'd0, 0, 0, "idle");

        // Stall for four cycles.
        cycle(1, 0, 7'd0, 0, 0, "stall"); check_val("stall_enbl", {31'd0, a_enbl}, 32'd0);
        repeat (3) cycle(1, 0, 7'd0, 0, 0, "stall");
        cycle(0, 0, 7'd0, 0, 0, "unstall"); check_val("unstall_state", {29'd0, a_state}, 32'd1);

        // Branch redirect.
        cycle(0, 1, 7'h2A, 0, 0, "branch");
        check_val("branch_out", {22'd0, a_enbl, a_dec, a_pc}, {22'd0, 1'b1, 1'b1, 7'h2A});
        cycle(0, 0, 7'd0, 0, 0, "post_branch");
        check_val("post_branch_state", {29'd0, a_state}, 32'd1);
        repeat (3) cycle(0, 0, 7'd0, 0, 0, "idle");

        // Branch wins over an ongoing stall, then back to STALL.
        cycle(1, 0, 7'd0, 0, 0, "pri_stall");
        cycle(1, 1, 7'h10, 0, 0, "pri_branch");
        check_val("pri_flush", {22'd0, a_state, a_dec, a_pc}, {22'd0, 3'd3, 1'b1, 7'h10});
        cycle(1, 0, 7'd0, 0, 0, "pri_back");
        check_val("pri_back_state", {29'd0, a_state}, 32'd2);
        repeat (4) cycle(0, 0, 7'd0, 0, 0, "idle");

        // Halt ignores branches; resume needs halt_req low.
        cycle(0, 0, 7'd0, 1, 0, "halt");
        check_val("halt_out", {28'd0, a_state, a_enbl}, {28'd0, 3'd4, 1'b0});
        cycle(1, 1, 7'h55, 1, 0, "halt_br"); check_val("halt_pc", {25'd0, a_pc}, 32'h10);
        cycle(0, 0, 7'd0, 1, 1, "halt_res_hi"); check_val("halt_hold", {29'd0, a_state}, 32'd4);
        cycle(0, 0, 7'd0, 0, 1, "resume"); check_val("resume_state", {29'd0, a_state}, 32'd1);

        // Reset landing in the second flush cycle of the FLUSH_CYCLES=3 instance.
        cycle(0, 1, 7'h3C, 0, 0, "fl_branch");
        cycle(0, 0, 7'd0, 0, 0, "fl_second");
        check_val("fl_second_b", {28'd0, b_state, b_dec}, {28'd0, 3'd3, 1'b1});
        do_reset("rst_flush");

        // Randomized traffic against the model.
        rs = 0; rh = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset("rnd_reset");
            end else begin
                if ($urandom_range(0, 3) == 0) rs = ~rs;
                if (rh) begin
                    if ($urandom_range(0, 3) == 0) rh = 1'b0;
                end else if ($urandom_range(0, 19) == 0) begin
                    rh = 1'b1;
                end
                rb = ($urandom_range(0, 5) == 0);
                rr = ($urandom_range(0, 3) == 0);
                rt = 7'($urandom);
                cycle(rs, rb, rt, rh, rr, "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
